am2906_rx_fifo: RTL

Receive-side controller for the parity bus driven by am2906 transceivers. Samples the active-low, wired-AND bus word and parity line on a strobe and checks even overall parity (data plus the transmitter's odd bit). Pushes each word with its error flag into a small show-ahead FIFO. Reports fill level, overflow and a saturating parity-error count, and drives a hold line back to the transmitter for flow control.

---
 rtl/am2906_rx_fifo.sv | 122 ++++++++++++
 1 files changed

// File: rtl/am2906_rx_fifo.sv
// Receive-side controller for an am2906 parity bus: samples the active-low bus on a strobe,
// checks even overall parity and queues {data, perr} in a show-ahead FIFO with flow control.
module am2906_rx_fifo #(
   parameter int WIDTH = 4,
   parameter int DEPTH = 4
) (
   input  logic                     cp,
   input  logic                     rst_,
   input  logic [WIDTH-1:0]         bus_,
   input  logic                     par_,
   input  logic                     stb_,
   input  logic                     pop,
   input  logic                     clr,
   output logic [WIDTH-1:0]         r,
   output logic                     rperr,
   output logic                     empty,
   output logic                     full,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     hold_,
   output logic                     ovf,
   output logic [7:0]               errcnt
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);
   localparam logic [CW-1:0] CNT_HOLD = CW'(DEPTH - 1);

   typedef struct packed {
      logic [WIDTH-1:0] data;
      logic             perr;
   } entry_t;

   // Captured word in true polarity; a good am2906 word has even parity over data plus odd bit.
   logic             strobe;
   logic [WIDTH-1:0] cap_data;
   logic             cap_perr;

   assign strobe   = ~stb_;
   assign cap_data = ~bus_;
   assign cap_perr = (^cap_data) ^ ~par_;

   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q,  count_d;
   logic          ovf_q,    ovf_d;
   logic [7:0]    errcnt_q, errcnt_d;

   entry_t mem_q [DEPTH];

   logic is_empty, is_full;
   logic do_push, do_pop, overflow_evt, error_evt;

   assign is_empty = (count_q == '0);
   assign is_full  = (count_q == CNT_FULL);

   // A pop frees a slot in the same cycle, so a full FIFO still accepts a word alongside a pop.
   assign do_pop       = pop & ~is_empty;
   assign do_push      = strobe & (~is_full | do_pop);
   assign overflow_evt = strobe & is_full & ~pop;
   assign error_evt    = strobe & cap_perr;

   always_comb begin
      // NOTE: every combinational output gets a default first so no path can infer a latch.
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      ovf_d    = ovf_q;
      errcnt_d = errcnt_q;

      if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);

      unique case ({do_push, do_pop})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase

      // clr has priority over a coinciding error or overflow event.
      if (clr) begin
         ovf_d    = 1'b0;
         errcnt_d = '0;
      end else begin
         if (overflow_evt) ovf_d = 1'b1;
         if (error_evt && errcnt_q != 8'hFF) errcnt_d = errcnt_q + 8'd1;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge cp or negedge rst_) begin
      if (!rst_) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         ovf_q    <= 1'b0;
         errcnt_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         ovf_q    <= ovf_d;
         errcnt_q <= errcnt_d;
      end
   end

   // NOTE: storage is deliberately not reset; count gates validity so its contents never matter when empty.
   always_ff @(posedge cp) begin
      if (do_push) mem_q[wr_ptr_q] <= '{data: cap_data, perr: cap_perr};
   end

   assign r      = mem_q[rd_ptr_q].data;
   assign rperr  = mem_q[rd_ptr_q].perr;
   assign empty  = is_empty;
   assign full   = is_full;
   assign count  = count_q;
   // Asserting one entry early leaves room for a transmitter that reacts a cycle late.
   assign hold_  = ~(count_q >= CNT_HOLD);
   assign ovf    = ovf_q;
   assign errcnt = errcnt_q;

endmodule
